// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and defaults for the confreg UART transmit path.
//               Serializer state encoding, default divisor/depth and a helper
//               returning the occupancy counter width for a given FIFO depth.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int unsigned UART_DIV_DEFAULT        = 868;
  localparam int unsigned UART_FIFO_DEPTH_DEFAULT = 16;

  // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int unsigned uart_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/confreg_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : confreg_uart_tx_if
// Description : Bus bundle between the confreg register decode (master) and
//               the UART transmit block (slave).
//   wr_en / wr_data         : byte write request
//   fifo_full / fifo_count  : FIFO status
//   overflow                : sticky dropped-write flag
//   tx_busy / uart_txd      : serializer status and serial line
//   write_uart_valid/_data  : one-cycle strobe carrying each popped byte
// Revision    : 1.0 - initial release
// ============================================================================
interface confreg_uart_tx_if
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_FIFO_DEPTH_DEFAULT
);
  logic                         wr_en;
  logic [7:0]                   wr_data;
  logic                         fifo_full;
  logic [uart_cnt_w(DEPTH)-1:0] fifo_count;
  logic                         overflow;
  logic                         tx_busy;
  logic                         write_uart_valid;
  logic [7:0]                   write_uart_data;
  logic                         uart_txd;

  modport master (
    output wr_en, wr_data,
    input  fifo_full, fifo_count, overflow, tx_busy,
           write_uart_valid, write_uart_data, uart_txd
  );

  modport slave (
    input  wr_en, wr_data,
    output fifo_full, fifo_count, overflow, tx_busy,
           write_uart_valid, write_uart_data, uart_txd
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Synchronous single-clock FIFO, head visible combinationally.
//   clk, resetn     : clock, synchronous active-low reset
//   push, din       : write request and data (ignored when full)
//   pop, dout       : read request (ignored when empty) and head data
//   full, empty     : status judged on the current (pre-edge) state
//   count           : occupancy 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = UART_FIFO_DEPTH_DEFAULT
) (
  input  wire logic                         clk,
  input  wire logic                         resetn,
  input  wire logic                         push,
  input  wire logic                         pop,
  input  wire logic [WIDTH-1:0]             din,
  output      logic [WIDTH-1:0]             dout,
  output      logic                         full,
  output      logic                         empty,
  output      logic [uart_cnt_w(DEPTH)-1:0] count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = uart_cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap without compare logic.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end
endmodule
`default_nettype wire

// File: rtl/confreg_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : confreg_uart_tx
// Description : confreg UART transmit path. Buffered byte writes are drained
//               one at a time; each pop raises a one-cycle registered strobe
//               and (serializer build) is sent 8N1 on uart_txd.
//   clk, resetn : clock, synchronous active-low reset
//   uart        : confreg_uart_tx_if.slave bundle (write, status, strobe, txd)
// Build macro : CONFREG_UART_TXD_EN
//   defined   - full serializer, DIV clock cycles per bit, 10*DIV per frame
//   undefined - no serializer; pops every cycle, uart_txd=1, tx_busy=0
// Revision    : 1.0 - initial release
// ============================================================================
module confreg_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DIV   = UART_DIV_DEFAULT,
  parameter int unsigned DEPTH = UART_FIFO_DEPTH_DEFAULT
) (
  input wire logic          clk,
  input wire logic          resetn,
  confreg_uart_tx_if.slave  uart
);
  localparam int unsigned CW = uart_cnt_w(DEPTH);

  if (DIV < 1 || DIV > 65535) begin : g_bad_div
    $error("confreg_uart_tx: DIV out of range 1..65535");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("confreg_uart_tx: DEPTH must be a power of two >= 2");
  end

  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          valid_q, valid_d;
  logic [7:0]    data_q, data_d;
  logic          ovf_q, ovf_d;

  uart_tx_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (uart.wr_en),
    .pop    (fifo_pop),
    .din    (uart.wr_data),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

`ifdef CONFREG_UART_TXD_EN
  uart_tx_state_t state_q, state_d;
  logic [15:0]    baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           txd_q, txd_d;
  logic           baud_wrap;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    baud_wrap = (baud_q == 16'(DIV - 1));
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = '0;
          bit_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is registered from the next state so it changes on the
    // same edge as the state itself (start bit falls on the pop edge).
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  assign uart.uart_txd = txd_q;
  assign uart.tx_busy  = (state_q != IDLE);
`else
  // Fast build: drain one byte per cycle, line held idle.
  assign fifo_pop      = ~fifo_empty;
  assign uart.uart_txd = 1'b1;
  assign uart.tx_busy  = 1'b0;
`endif

  // Full is the pre-edge status, so a write racing a pop from a full FIFO
  // is dropped and flagged.
  always_comb begin
    valid_d = fifo_pop;
    data_d  = fifo_pop ? fifo_dout : data_q;
    ovf_d   = ovf_q | (uart.wr_en & fifo_full);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign uart.write_uart_valid = valid_q;
  assign uart.write_uart_data  = data_q;
  assign uart.overflow         = ovf_q;
  assign uart.fifo_full        = fifo_full;
  assign uart.fifo_count       = fifo_count;
endmodule
`default_nettype wire

// File: tb/tb_confreg_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_confreg_uart_tx
// Description : Self-checking bench for confreg_uart_tx (DIV=4, DEPTH=4).
//               A queue-based reference model predicts pops, strobes, FIFO
//               occupancy, overflow and the serial waveform from the frame
//               timing (pop every 10*DIV+1 cycles at most, bit = k/DIV).
// Build macro : CONFREG_UART_TXD_EN selects serializer or fast expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_confreg_uart_tx;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
`ifdef CONFREG_UART_TXD_EN
  localparam int FRAME = 10 * DIV;
`else
  localparam int FRAME = 0;
`endif
  localparam int RATE = (FRAME > 0) ? 6 : 60;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  confreg_uart_tx_if #(.DEPTH(DEPTH)) uart ();

  confreg_uart_tx #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .uart   (uart)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] m_q [$];
  int         cyc      = 0;
  int         free_at  = 0;
  int         last_pop = -100000;
  logic       m_ovf = 1'b0, m_valid = 1'b0, m_busy = 1'b0, m_txd = 1'b1;
  logic [7:0] m_data = '0, m_cur = '0;
  int         m_count = 0;

  always @(posedge clk) begin : b_model
    int e, pre, k, idx;
    bit do_pop, do_push;
    e   = cyc;
    cyc = cyc + 1;
    if (!resetn) begin
      m_q.delete();
      m_ovf    = 1'b0;
      m_valid  = 1'b0;
      m_data   = '0;
      free_at  = 0;
      last_pop = -100000;
    end else begin
      pre     = m_q.size();
      do_pop  = (pre != 0) && (e >= free_at);
      do_push = (uart.wr_en === 1'b1) && (pre < DEPTH);
      if (uart.wr_en === 1'b1 && !do_push) m_ovf = 1'b1;
      m_valid = 1'b0;
      if (do_pop) begin
        m_cur    = m_q.pop_front();
        m_data   = m_cur;
        m_valid  = 1'b1;
        last_pop = e;
        free_at  = e + FRAME + 1;
      end
      if (do_push) m_q.push_back(uart.wr_data);
    end
    k      = e - last_pop;
    m_busy = 1'b0;
    m_txd  = 1'b1;
    if (k >= 0 && k < FRAME) begin
      m_busy = 1'b1;
      idx    = k / DIV;
      if (idx == 0)      m_txd = 1'b0;
      else if (idx <= 8) m_txd = m_cur[idx-1];
    end
    m_count = m_q.size();
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic pulse_reset();
    resetn      = 1'b0;
    uart.wr_en  = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn       = 1'b0;
    uart.wr_en   = 1'b0;
    uart.wr_data = '0;
    repeat (3) begin
      @(negedge clk);
      n_checks++; if (uart.uart_txd !== 1'b1) begin n_fail++; $display("FAIL reset txd: got %b want 1", uart.uart_txd); end
      n_checks++; if (uart.fifo_count !== '0) begin n_fail++; $display("FAIL reset count: got %0d want 0", uart.fifo_count); end
      n_checks++; if (uart.fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset full: got %b want 0", uart.fifo_full); end
      n_checks++; if (uart.overflow !== 1'b0) begin n_fail++; $display("FAIL reset overflow: got %b want 0", uart.overflow); end
      n_checks++; if (uart.tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", uart.tx_busy); end
      n_checks++; if (uart.write_uart_valid !== 1'b0) begin n_fail++; $display("FAIL reset valid: got %b want 0", uart.write_uart_valid); end
      n_checks++; if (uart.write_uart_data !== 8'h00) begin n_fail++; $display("FAIL reset data: got %h want 00", uart.write_uart_data); end
    end
    resetn = 1'b1;
  endtask

  task automatic test_single();
    uart.wr_en   = 1'b1;
    uart.wr_data = 8'h41;
    @(negedge clk);
    uart.wr_en = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      n_checks++; if (uart.uart_txd !== m_txd) begin n_fail++; $display("FAIL single txd i=%0d: got %b want %b", i, uart.uart_txd, m_txd); end
      n_checks++; if (uart.tx_busy !== m_busy) begin n_fail++; $display("FAIL single busy i=%0d: got %b want %b", i, uart.tx_busy, m_busy); end
      n_checks++; if (uart.write_uart_valid !== (i == 1)) begin n_fail++; $display("FAIL single valid i=%0d: got %b want %b", i, uart.write_uart_valid, (i == 1)); end
      n_checks++; if (uart.fifo_count !== m_count[2:0]) begin n_fail++; $display("FAIL single count i=%0d: got %0d want %0d", i, uart.fifo_count, m_count); end
      if (i == 1) begin
        n_checks++; if (uart.write_uart_data !== 8'h41) begin n_fail++; $display("FAIL single data: got %h want 41", uart.write_uart_data); end
      end
`ifdef CONFREG_UART_TXD_EN
      if (i == 40 || i == 41) begin
        n_checks++; if (uart.tx_busy !== (i == 40)) begin n_fail++; $display("FAIL single busy_edge i=%0d: got %b want %b", i, uart.tx_busy, (i == 40)); end
      end
`endif
    end
  endtask

  task automatic test_overflow();
    logic [7:0] got [$];
    int         when [$];
    int         n_exp;
    pulse_reset();
    for (int i = 0; i < 230; i++) begin
      uart.wr_en   = (i < 6);
      uart.wr_data = 8'(i + 1);
      @(negedge clk);
      n_checks++; if (uart.write_uart_valid !== m_valid) begin n_fail++; $display("FAIL overflow valid i=%0d: got %b want %b", i, uart.write_uart_valid, m_valid); end
      if (uart.write_uart_valid === 1'b1) begin
        got.push_back(uart.write_uart_data);
        when.push_back(cyc);
      end
    end
    n_exp = (FRAME > 0) ? 5 : 6;
    n_checks++; if (uart.overflow !== (FRAME > 0)) begin n_fail++; $display("FAIL overflow flag: got %b want %b", uart.overflow, (FRAME > 0)); end
    n_checks++; if (got.size() != n_exp) begin n_fail++; $display("FAIL overflow strobes: got %0d want %0d", got.size(), n_exp); end
    for (int j = 0; j < got.size(); j++) begin
      n_checks++; if (got[j] !== 8'(j + 1)) begin n_fail++; $display("FAIL overflow byte %0d: got %h want %h", j, got[j], 8'(j + 1)); end
      if (j > 0) begin
        n_checks++; if (when[j] - when[j-1] != FRAME + 1) begin n_fail++; $display("FAIL overflow spacing %0d: got %0d want %0d", j, when[j] - when[j-1], FRAME + 1); end
      end
    end
  endtask

`ifdef CONFREG_UART_TXD_EN
  task automatic test_full_pop();
    logic [7:0] first;
    pulse_reset();
    first = 8'($urandom);
    for (int i = 0; i < 5; i++) begin
      uart.wr_en   = 1'b1;
      uart.wr_data = (i == 0) ? first : 8'($urandom);
      @(negedge clk);
    end
    uart.wr_en = 1'b0;
    first = m_q[0];
    n_checks++; if (uart.fifo_count !== 3'd4) begin n_fail++; $display("FAIL fullpop count_before: got %0d want 4", uart.fifo_count); end
    n_checks++; if (uart.fifo_full !== 1'b1) begin n_fail++; $display("FAIL fullpop full_before: got %b want 1", uart.fifo_full); end
    for (int t = 0; t < 100 && cyc != free_at; t++) @(negedge clk);
    n_checks++; if (cyc != free_at) begin n_fail++; $display("FAIL fullpop wait: got cyc %0d want %0d", cyc, free_at); end
    uart.wr_en   = 1'b1;
    uart.wr_data = 8'h77;
    @(negedge clk);
    uart.wr_en = 1'b0;
    n_checks++; if (uart.fifo_count !== 3'd3) begin n_fail++; $display("FAIL fullpop count_after: got %0d want 3", uart.fifo_count); end
    n_checks++; if (uart.overflow !== 1'b1) begin n_fail++; $display("FAIL fullpop overflow: got %b want 1", uart.overflow); end
    n_checks++; if (uart.write_uart_valid !== 1'b1) begin n_fail++; $display("FAIL fullpop valid: got %b want 1", uart.write_uart_valid); end
    n_checks++; if (uart.write_uart_data !== first) begin n_fail++; $display("FAIL fullpop data: got %h want %h", uart.write_uart_data, first); end
  endtask

  task automatic test_reset_mid();
    int strobes;
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      uart.wr_en   = 1'b1;
      uart.wr_data = 8'($urandom);
      @(negedge clk);
    end
    uart.wr_en = 1'b0;
    for (int t = 0; t < 100 && (cyc - 1 - last_pop) != 17; t++) @(negedge clk);
    n_checks++; if ((cyc - 1 - last_pop) != 17) begin n_fail++; $display("FAIL midreset wait: got k=%0d want 17", cyc - 1 - last_pop); end
    n_checks++; if (uart.fifo_count !== 3'd2) begin n_fail++; $display("FAIL midreset queued: got %0d want 2", uart.fifo_count); end
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    n_checks++; if (uart.uart_txd !== 1'b1) begin n_fail++; $display("FAIL midreset txd: got %b want 1", uart.uart_txd); end
    n_checks++; if (uart.fifo_count !== '0) begin n_fail++; $display("FAIL midreset count: got %0d want 0", uart.fifo_count); end
    n_checks++; if (uart.tx_busy !== 1'b0) begin n_fail++; $display("FAIL midreset busy: got %b want 0", uart.tx_busy); end
    strobes = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (uart.write_uart_valid !== 1'b0) strobes++;
      n_checks++; if (uart.uart_txd !== 1'b1) begin n_fail++; $display("FAIL midreset idle_txd i=%0d: got %b want 1", i, uart.uart_txd); end
    end
    n_checks++; if (strobes != 0) begin n_fail++; $display("FAIL midreset strobes: got %0d want 0", strobes); end
  endtask
`else
  task automatic test_fast_seq();
    logic [7:0] exp [3];
    exp[0] = 8'hFF; exp[1] = 8'h0A; exp[2] = 8'h0D;
    pulse_reset();
    for (int j = 0; j < 6; j++) begin
      uart.wr_en   = (j < 3);
      uart.wr_data = (j < 3) ? exp[j] : 8'h00;
      @(negedge clk);
      n_checks++; if (uart.write_uart_valid !== (j >= 1 && j <= 3)) begin n_fail++; $display("FAIL fast valid j=%0d: got %b want %b", j, uart.write_uart_valid, (j >= 1 && j <= 3)); end
      if (j >= 1 && j <= 3) begin
        n_checks++; if (uart.write_uart_data !== exp[j-1]) begin n_fail++; $display("FAIL fast data j=%0d: got %h want %h", j, uart.write_uart_data, exp[j-1]); end
      end
      n_checks++; if (uart.uart_txd !== 1'b1) begin n_fail++; $display("FAIL fast txd j=%0d: got %b want 1", j, uart.uart_txd); end
    end
  endtask
`endif

  task automatic test_random();
    pulse_reset();
    for (int i = 0; i < 1000; i++) begin
      uart.wr_en   = (i < 700) && ($urandom_range(0, 99) < RATE);
      uart.wr_data = 8'($urandom);
      @(negedge clk);
      n_checks++; if (uart.uart_txd !== m_txd) begin n_fail++; $display("FAIL random txd i=%0d: got %b want %b", i, uart.uart_txd, m_txd); end
      n_checks++; if (uart.tx_busy !== m_busy) begin n_fail++; $display("FAIL random busy i=%0d: got %b want %b", i, uart.tx_busy, m_busy); end
      n_checks++; if (uart.write_uart_valid !== m_valid) begin n_fail++; $display("FAIL random valid i=%0d: got %b want %b", i, uart.write_uart_valid, m_valid); end
      if (m_valid) begin
        n_checks++; if (uart.write_uart_data !== m_data) begin n_fail++; $display("FAIL random data i=%0d: got %h want %h", i, uart.write_uart_data, m_data); end
      end
      n_checks++; if (uart.fifo_count !== m_count[2:0]) begin n_fail++; $display("FAIL random count i=%0d: got %0d want %0d", i, uart.fifo_count, m_count); end
      n_checks++; if (uart.fifo_full !== (m_count == DEPTH)) begin n_fail++; $display("FAIL random full i=%0d: got %b want %b", i, uart.fifo_full, (m_count == DEPTH)); end
      n_checks++; if (uart.overflow !== m_ovf) begin n_fail++; $display("FAIL random overflow i=%0d: got %b want %b", i, uart.overflow, m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
`ifdef CONFREG_UART_TXD_EN
    test_full_pop();
    test_reset_mid();
`else
    test_fast_seq();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire

// File: doc/confreg_uart_tx.md
# confreg_uart_tx

Byte-oriented UART transmit path for the confreg peripheral block. CPU stores to the confreg UART data register are buffered in a small FIFO and drained one byte at a time. Each drained byte raises a one-cycle `write_uart_valid`/`write_uart_data` strobe, which simulation benches use for console display and end-of-test detection (byte 0xFF). The same byte is serialized 8N1 on `uart_txd` for the board.

## Interface
Parameters:
- `DIV`, 868: clock cycles per serial bit (100 MHz / 115200); legal range 1..65535.
- `DEPTH`, 16: FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock for all logic.
- `resetn`  in  1  reset, synchronous and active-low.
- `wr_en`  in  1  byte write request from the confreg register decode.
- `wr_data`  in  8  byte to transmit.
- `fifo_full`  out  1  FIFO holds `DEPTH` bytes.
- `fifo_count`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky flag: a write was dropped.
- `tx_busy`  out  1  serializer not IDLE.
- `write_uart_valid`  out  1  one-cycle pulse when a byte is popped.
- `write_uart_data`  out  8  popped byte; valid only with the strobe.
- `uart_txd`  out  1  serial line, idle high.

## Operation
- Reset (`resetn`=0 at a `clk` edge) sets the following:
  - FIFO empty; `fifo_count`=0; `fifo_full`=0; `overflow`=0; `tx_busy`=0.
  - `write_uart_valid`=0; `write_uart_data`=0; `uart_txd`=1.
  - FSM=IDLE; bit and baud counters cleared.
- Reset mid-byte abandons the byte and discards all queued bytes. `uart_txd` returns high immediately after the reset edge.
- Write: `wr_en`=1 with `fifo_full`=0 stores `wr_data` at the tail.
  - `wr_en`=1 with `fifo_full`=1 drops the byte and sets `overflow`. `overflow` clears only on reset.
  - Full is judged on the pre-edge state: a write in the same cycle as a pop from a full FIFO is still dropped.
- Pop: happens when FSM=IDLE and `fifo_count`≠0.
  - Head moves to the shift register.
  - `write_uart_valid`=1 and `write_uart_data`=head, both registered, for exactly one cycle.
  - FSM→START.
- No bypass: a write into an empty FIFO cannot pop in the same cycle.
- Simultaneous write and pop: `fifo_count` is unchanged.
- Data bytes, 0xFF included, get no special treatment.
- FSM, each non-IDLE state lasting `DIV` cycles on a baud counter:
  - IDLE: `uart_txd`=1; leave on pop.
  - START: `uart_txd`=0; →DATA.
  - DATA: `uart_txd`=shift[0], LSB first. After each bit: shift right, bit counter +1. After 8 bits →STOP.
  - STOP: `uart_txd`=1; →IDLE.
- `tx_busy`=1 in START/DATA/STOP.

## Timing
- Write at edge N: pop and strobe are registered at edge N+1 (strobe high during cycle N+1..N+2). `uart_txd` falls at edge N+1.
- Byte frame: 10·`DIV` cycles. IDLE holds at least one cycle between frames, so the back-to-back period is 10·`DIV`+1 cycles.
- `fifo_count`/`fifo_full` update at the edge after the write or pop.
- Baud counter counts 0..`DIV`-1 and wraps. A state change occurs on the wrap edge.
- FIFO pointers are log2(`DEPTH`) bits and wrap naturally.

## Configuration
- `CONFREG_UART_TXD_EN` defined: full serializer as described.
- `CONFREG_UART_TXD_EN` undefined (simulation/fast build):
  - No FSM or baud counter.
  - A pop occurs on every cycle with `fifo_count`≠0, giving one strobe per cycle, back-to-back.
  - `uart_txd` is tied to 1 and `tx_busy` is tied to 0.
  - Write-to-strobe latency stays 1 edge.

## Structure
- Shared package `uart_pkg`: `uart_tx_state_t` enum (IDLE, START, DATA, STOP), `UART_DIV_DEFAULT`=868, `UART_FIFO_DEPTH_DEFAULT`=16.
- Sub-module `uart_tx_fifo`: synchronous single-clock FIFO, parameters `WIDTH`=8 and `DEPTH`. It exposes `push`, `pop`, `din`, `dout` (head, combinational), `full`, `empty`, `count`.
- `confreg_uart_tx` holds the FSM, shift register, counters, strobe registers and overflow flag.

## Test plan
All scenarios use `DIV`=4, `DEPTH`=4, macro defined unless stated.
- Reset values: hold `resetn`=0 for 3 cycles, then release. All outputs take their reset values, `uart_txd`=1 throughout.
- Single byte 0x41 written at edge N:
  - Strobe with data 0x41 at N+1.
  - `uart_txd` shows 0 for 4 cycles, then 1,0,0,0,0,0,1,0 (4 cycles each), then 1.
  - `tx_busy` falls at N+41.
- Overflow: write 0x01..0x06 on consecutive cycles.
  - First byte pops at the following edge. The next four fill the FIFO; the sixth is dropped.
  - `overflow`=1; strobes emit 0x01..0x05 only, spaced 41 cycles.
- Full plus simultaneous pop: fill the FIFO while FSM=IDLE, then write in the pop cycle. The write is dropped, `overflow` is set, and `fifo_count` goes 4→3.
- Reset mid-frame: assert `resetn`=0 during DATA bit 3 with 2 bytes queued.
  - After the edge: `uart_txd`=1, `fifo_count`=0, no further strobes.
- Macro undefined: write 0xFF, 0x0A, 0x0D on consecutive cycles. Strobes follow on consecutive cycles with the same values; `uart_txd` stays 1.
